// File: rtl/bcd_arb_pkg.sv
// bcd_arb_pkg: shared FSM state type and requester-index sizing helper for bcd_conv_arbiter.
package bcd_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  function automatic int REQ_ID_W(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: circular first-set search of a request vector starting at a pointer;
// returns one-hot grant, its index and whether anything was requesting.
module rr_priority_picker
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = REQ_ID_W(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);
  always_comb begin
    int k;
    k = 0;
    o_grant = '0;
    o_idx = '0;
    o_valid = |i_req;
    // walk from farthest offset down so the nearest requester at/after the pointer wins
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(i_ptr) + i) % N_REQ;
      if (i_req[k]) begin
        o_grant = '0;
        o_grant[k] = 1'b1;
        o_idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter sharing one binary-to-BCD converter among N_REQ requesters.
// Optional watchdog on the converter wait enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_N = 16,
  parameter int BCD_N = 20,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*BIN_N-1:0] bin_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [BCD_N-1:0]       bcd_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic                   conv_start_o,
  output logic [BIN_N-1:0]       conv_bin_o,
  input  logic                   conv_ready_i,
  input  logic                   conv_done_i,
  input  logic [BCD_N-1:0]       conv_bcd_i
);
  localparam int IW = REQ_ID_W(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bcd_conv_arbiter: unsupported parameter set");
  end
  state_t           r_state, w_next;
  logic [IW-1:0]    r_ptr, r_gnt, w_ptr_nxt, w_pick_idx;
  logic [N_REQ-1:0] w_pick_gnt, w_gnt_oh;
  logic             w_pick_vld, w_timeout;
  logic [BIN_N-1:0] r_conv_bin, w_bin_sel;
  logic [BCD_N-1:0] r_bcd;
  rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );
  always_comb begin
    w_bin_sel = '0;
    for (int k = 0; k < N_REQ; k++) w_bin_sel = w_pick_gnt[k] ? bin_i[k*BIN_N +: BIN_N] : w_bin_sel;
  end
`ifdef BCD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_wd <= '0;
    else r_wd <= (r_state == ST_WAIT) ? r_wd + 1'b1 : '0;
  end
  assign w_timeout = (r_state == ST_WAIT) && !conv_done_i && (r_wd == WD_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif
  assign w_ptr_nxt = (r_gnt == IW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_gnt_oh = N_REQ'(1) << r_gnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_pick_vld ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_next = conv_ready_i ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  w_next = conv_done_i ? ST_DONE : (w_timeout ? ST_IDLE : ST_WAIT);
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_ptr <= '0;
      r_gnt <= '0;
      r_conv_bin <= '0;
      r_bcd <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_pick_vld) begin
        r_gnt <= w_pick_idx;
        r_conv_bin <= w_bin_sel;
      end
      if (r_state == ST_WAIT && conv_done_i) r_bcd <= conv_bcd_i;
      if (r_state == ST_DONE || w_timeout) r_ptr <= w_ptr_nxt;
    end
  end
  // a requester that dropped its request before DONE still sees the result in bcd_o, but no ack
  assign ack_o = (r_state == ST_DONE) ? (req_i & w_gnt_oh) : '0;
  assign conv_start_o = (r_state == ST_ISSUE) && conv_ready_i;
  assign busy_o = r_state != ST_IDLE;
  assign err_o = w_timeout;
  assign bcd_o = r_bcd;
  assign conv_bin_o = r_conv_bin;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: table-driven directed bench for bcd_conv_arbiter with hand-driven converter.
module tb_bcd_conv_arbiter;
`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [63:0] BINS = {16'd9999, 16'd777, 16'd5678, 16'd1234};
  logic clk_i = 1'b0, reset_i = 1'b1;
  logic [3:0] req_i = '0;
  logic [63:0] bin_i = '0;
  logic conv_ready_i = 1'b0, conv_done_i = 1'b0;
  logic [19:0] conv_bcd_i = '0;
  logic [3:0] ack_o;
  logic [19:0] bcd_o;
  logic busy_o, err_o, conv_start_o;
  logic [15:0] conv_bin_o;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [3:0]  req;
    int          k;
    logic [15:0] opnd;
    logic [19:0] res;
    bit          drop;
  } vec_t;
  vec_t tv[11];
  always #5 clk_i = ~clk_i;
  bcd_conv_arbiter #(.N_REQ(4), .BIN_N(16), .BCD_N(20), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .bin_i(bin_i), .ack_o(ack_o),
    .bcd_o(bcd_o), .busy_o(busy_o), .err_o(err_o), .conv_start_o(conv_start_o),
    .conv_bin_o(conv_bin_o), .conv_ready_i(conv_ready_i), .conv_done_i(conv_done_i),
    .conv_bcd_i(conv_bcd_i)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic finish_done(input logic [19:0] res, input logic [3:0] exp_ack);
    @(posedge clk_i); #1; conv_done_i = 1'b1; conv_bcd_i = res;
    @(posedge clk_i); #1; conv_done_i = 1'b0; conv_bcd_i = '0;
    @(negedge clk_i);
    check("ack", ack_o, exp_ack);
    check("bcd", bcd_o, res);
    @(posedge clk_i); #1; req_i = '0;
    @(negedge clk_i);
    check("ack_pulse_end", ack_o, 0);
    check("idle_busy", busy_o, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{4'b1111, 0, 16'd1234, 20'h01234, 1'b0};
    tv[1]  = '{4'b1111, 1, 16'd5678, 20'h05678, 1'b0};
    tv[2]  = '{4'b1111, 2, 16'd777,  20'h00777, 1'b0};
    tv[3]  = '{4'b1111, 3, 16'd9999, 20'h09999, 1'b0};
    tv[4]  = '{4'b1111, 0, 16'd1234, 20'h01234, 1'b0};
    tv[5]  = '{4'b0001, 0, 16'd1234, 20'h01234, 1'b0};
    tv[6]  = '{4'b1000, 3, 16'd9999, 20'h09999, 1'b0};
    tv[7]  = '{4'b0110, 1, 16'd5678, 20'h05678, 1'b0};
    tv[8]  = '{4'b0101, 2, 16'd777,  20'h00777, 1'b1};
    tv[9]  = '{4'b0111, 0, 16'd1234, 20'h01234, 1'b0};
    tv[10] = '{4'b1001, 3, 16'd9999, 20'h09999, 1'b0};
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_bcd", bcd_o, 0);
    check("rst_err", err_o, 0);
    check("rst_start", conv_start_o, 0);
    check("rst_conv_bin", conv_bin_o, 0);
    @(posedge clk_i); #1; reset_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk_i); #1; req_i = tv[i].req; bin_i = BINS; conv_ready_i = 1'b1;
      @(posedge clk_i); #1; bin_i = ~BINS;
      @(negedge clk_i);
      check("start", conv_start_o, 1);
      check("conv_bin", conv_bin_o, tv[i].opnd);
      @(posedge clk_i); #1;
      if (tv[i].drop) req_i[tv[i].k] = 1'b0;
      @(negedge clk_i);
      check("wait_start_low", conv_start_o, 0);
      check("wait_conv_bin", conv_bin_o, tv[i].opnd);
      finish_done(tv[i].res, tv[i].drop ? 4'b0 : 4'(1 << tv[i].k));
    end
    // converter not ready for 5 cycles while in ISSUE
    @(posedge clk_i); #1; req_i = 4'b0100; bin_i = BINS; conv_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("issue_hold_start", conv_start_o, 0);
      check("issue_hold_busy", busy_o, 1);
    end
    @(posedge clk_i); #1; conv_ready_i = 1'b1;
    @(negedge clk_i);
    check("ready_start", conv_start_o, 1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("ready_single", conv_start_o, 0);
    finish_done(20'h00777, 4'b0100);
    // reset during WAIT, then a stale done
    @(posedge clk_i); #1; req_i = 4'b0010;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rstw_busy_pre", busy_o, 1);
    #1; reset_i = 1'b1; req_i = '0;
    #1;
    check("rstw_busy", busy_o, 0);
    check("rstw_bcd", bcd_o, 0);
    check("rstw_conv_bin", conv_bin_o, 0);
    @(posedge clk_i); #1; reset_i = 1'b0; conv_done_i = 1'b1; conv_bcd_i = 20'h05678;
    @(posedge clk_i); #1; conv_done_i = 1'b0; conv_bcd_i = '0;
    @(negedge clk_i);
    check("late_done_ack", ack_o, 0);
    check("late_done_bcd", bcd_o, 0);
    check("late_done_busy", busy_o, 0);
    // long converter stall
    @(posedge clk_i); #1; req_i = 4'b0001;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
`ifdef BCD_ARB_TIMEOUT_EN
    for (int j = 0; j < TO; j++) begin
      @(negedge clk_i);
      check("wd_no_err", err_o, 0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("wd_err", err_o, 1);
    check("wd_ack", ack_o, 0);
    @(posedge clk_i); #1; req_i = '0;
    @(negedge clk_i);
    check("wd_err_pulse", err_o, 0);
    check("wd_busy", busy_o, 0);
`else
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_i);
      check("stall_err", err_o, 0);
      check("stall_busy", busy_o, 1);
      @(posedge clk_i); #1;
    end
    finish_done(20'h01234, 4'b0001);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
